// File: rtl/acc_pkg.sv
// Shared types and default widths for the accumulator stage and its ALU.
package acc_pkg;

  localparam int ACC_DATA_W  = 16;
  localparam int ACC_INDEX_W = 5;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_COMMIT = 2'b10,
    ST_FULL   = 2'b11
  } state_e;

endpackage

// File: rtl/acc_alu.sv
// Combinational add/sub/load/clear with signed-overflow detection.
// ACC_SATURATE_EN defined: overflowing ADD/SUB clamps to the signed limits;
// otherwise the result wraps around in two's complement.
module acc_alu
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W
) (
  input  op_e                       op_code,
  input  logic signed [DATA_W-1:0]  acc,
  input  logic signed [DATA_W-1:0]  operand,
  output logic signed [DATA_W-1:0]  result,
  output logic                      ovf
);

`ifdef ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  // Overflow can only go past the limit on the side of the original accumulator sign.
  function automatic logic signed [DATA_W-1:0] saturate(
    input logic signed [DATA_W-1:0] wrapped,
    input logic                     neg,
    input bit                       en
  );
    if (!en)
      return wrapped;
    return neg ? MIN_VAL : MAX_VAL;
  endfunction

  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;

  // Select the op result and flag signed overflow for ADD/SUB.
  always_comb begin
    sum    = acc + operand;
    diff   = acc - operand;
    result = acc;
    ovf    = 1'b0;
    case (op_code)
      OP_ADD: begin
        result = sum;
        ovf    = (acc[DATA_W-1] == operand[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (acc[DATA_W-1] != operand[DATA_W-1]) && (diff[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_LOAD:  result = operand;
      OP_CLEAR: result = '0;
      default:  result = acc;
    endcase
    if (ovf)
      result = saturate(result, acc[DATA_W-1], SAT_EN);
  end

endmodule

// File: rtl/accumulator_stage.sv
// Accumulates a handshaked op stream and feeds the 32-slot output register:
// a commit produces one write_enable pulse at the current slot, then the
// slot pointer advances (no wrap; the last slot sets full).
// Optional feature macro: ACC_SATURATE_EN (saturating ADD/SUB, see acc_alu).
module accumulator_stage
  import acc_pkg::*;
#(
  parameter int DATA_W  = ACC_DATA_W,
  parameter int INDEX_W = ACC_INDEX_W,
  parameter int DEPTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [1:0]                op_code,
  input  logic signed [DATA_W-1:0]  operand,
  input  logic                      commit_valid,
  output logic                      commit_ready,
  input  logic                      index_clear,
  output logic signed [DATA_W-1:0]  acc_value,
  output logic [INDEX_W-1:0]        output_index,
  output logic                      write_enable,
  output logic                      full,
  output logic                      overflow
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

  state_e                   state;
  state_e                   state_n;
  logic signed [DATA_W-1:0] acc;
  logic [INDEX_W-1:0]       idx;
  logic                     full_r;
  logic                     ovf_r;
  logic signed [DATA_W-1:0] alu_result;
  logic                     alu_ovf;
  logic                     op_fire;
  logic                     commit_fire;
  op_e                      op;

  assign op           = op_e'(op_code);
  assign op_ready     = (state != ST_COMMIT);
  // Ops win over commits, and index_clear wins over a same-cycle commit.
  assign commit_ready = ((state == ST_IDLE) || (state == ST_ACCUM)) && !op_valid && !index_clear;
  assign op_fire      = op_valid && op_ready;
  assign commit_fire  = commit_valid && commit_ready;

  assign acc_value    = acc;
  assign output_index = idx;
  assign write_enable = (state == ST_COMMIT);
  assign full         = full_r;
  assign overflow     = ovf_r;

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op_code (op),
    .acc     (acc),
    .operand (operand),
    .result  (alu_result),
    .ovf     (alu_ovf)
  );

  // Next-state logic for the commit/full sequencing.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (commit_fire)  state_n = ST_COMMIT;
        else if (op_fire) state_n = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (commit_fire) state_n = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (index_clear)        state_n = ST_ACCUM;
        else if (idx == LAST_IDX) state_n = ST_FULL;
        else                    state_n = ST_ACCUM;
      end
      ST_FULL: begin
        if (index_clear) state_n = ST_ACCUM;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, slot pointer and full flag; the pointer moves only after the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      full_r <= 1'b0;
    end else begin
      state <= state_n;
      if (index_clear) begin
        idx    <= '0;
        full_r <= 1'b0;
      end else if (state == ST_COMMIT) begin
        if (idx == LAST_IDX) full_r <= 1'b1;
        else                 idx    <= idx + 1'b1;
      end
    end
  end

  // Accumulator and sticky overflow, updated on every accepted op.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      ovf_r <= 1'b0;
    end else if (op_fire) begin
      acc <= alu_result;
      if (op == OP_CLEAR)  ovf_r <= 1'b0;
      else if (alu_ovf)    ovf_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accumulator_stage.sv
// Self-checking bench for accumulator_stage: directed scenarios followed by
// randomized traffic, all compared against an integer-arithmetic reference model.
module tb_accumulator_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic               op_valid;
  logic               op_ready;
  logic [1:0]         op_code;
  logic signed [15:0] operand;
  logic               commit_valid;
  logic               commit_ready;
  logic               index_clear;
  logic signed [15:0] acc_value;
  logic [4:0]         output_index;
  logic               write_enable;
  logic               full;
  logic               overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers and flags.
  int m_acc;
  bit m_ovf;
  int m_idx;
  bit m_full;
  bit m_busy;   // a write strobe is being driven this cycle

  always #5 clk = ~clk;

  accumulator_stage dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .operand      (operand),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .index_clear  (index_clear),
    .acc_value    (acc_value),
    .output_index (output_index),
    .write_enable (write_enable),
    .full         (full),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_ovf  = 0;
    m_idx  = 0;
    m_full = 0;
    m_busy = 0;
  endtask

  task automatic check_outputs();
    check("acc_value",    {16'h0, acc_value},    m_acc & 32'hFFFF);
    check("output_index", {27'h0, output_index}, m_idx);
    check("write_enable", {31'h0, write_enable}, m_busy);
    check("full",         {31'h0, full},         m_full);
    check("overflow",     {31'h0, overflow},     m_ovf);
  endtask

  // Apply one cycle of inputs (entered and left at a negedge).
  task automatic step(input bit r, input bit ov, input logic [1:0] oc,
                      input logic signed [15:0] opnd, input bit cv, input bit ic);
    int  res;
    bit  exp_op_rdy;
    bit  exp_cm_rdy;
    logic signed [15:0] w;
    rst          = r;
    op_valid     = ov;
    op_code      = oc;
    operand      = opnd;
    commit_valid = cv;
    index_clear  = ic;
    #1;
    exp_op_rdy = !m_busy;
    exp_cm_rdy = !m_busy && !m_full && !ov && !ic;
    check("op_ready",     {31'h0, op_ready},     exp_op_rdy);
    check("commit_ready", {31'h0, commit_ready}, exp_cm_rdy);
    if (r) begin
      model_reset();
    end else begin
      if (ov && exp_op_rdy) begin
        case (oc)
          2'b00, 2'b01: begin
            res = (oc == 2'b00) ? m_acc + int'(opnd) : m_acc - int'(opnd);
            if (res > 32767 || res < -32768) begin
              m_ovf = 1;
`ifdef ACC_SATURATE_EN
              res = (res > 32767) ? 32767 : -32768;
`else
              w   = res[15:0];
              res = int'(w);
`endif
            end
            m_acc = res;
          end
          2'b10: m_acc = int'(opnd);
          default: begin
            m_acc = 0;
            m_ovf = 0;
          end
        endcase
      end
      if (m_busy) begin
        if (ic) begin
          m_idx  = 0;
          m_full = 0;
        end else if (m_idx == 31) m_full = 1;
        else m_idx = m_idx + 1;
        m_busy = 0;
      end else begin
        if (ic) begin
          m_idx  = 0;
          m_full = 0;
        end
        if (cv && exp_cm_rdy) m_busy = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 16'sd0, 0, 0);
  endtask

  int writes;
  int mode;

  initial begin
    rst = 1; op_valid = 0; op_code = 0; operand = 0; commit_valid = 0; index_clear = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 0;

    // 1: LOAD 5, ADD 3, SUB 1
    step(0, 1, 2'b10, 16'sd5, 0, 0);
    check("t1_load", {16'h0, acc_value}, 32'd5);
    step(0, 1, 2'b00, 16'sd3, 0, 0);
    check("t1_add", {16'h0, acc_value}, 32'd8);
    step(0, 1, 2'b01, 16'sd1, 0, 0);
    check("t1_sub", {16'h0, acc_value}, 32'd7);
    check("t1_ovf", {31'h0, overflow}, 32'd0);

    // 2: overflow, then CLEAR
    step(0, 1, 2'b10, 16'sh7FFF, 0, 0);
    step(0, 1, 2'b00, 16'sd1, 0, 0);
    check("t2_ovf", {31'h0, overflow}, 32'd1);
`ifdef ACC_SATURATE_EN
    check("t2_acc", {16'h0, acc_value}, 32'h7FFF);
`else
    check("t2_acc", {16'h0, acc_value}, 32'h8000);
`endif
    step(0, 1, 2'b11, 16'sd0, 0, 0);
    check("t2_clr_acc", {16'h0, acc_value}, 32'd0);
    check("t2_clr_ovf", {31'h0, overflow}, 32'd0);

    // 3: LOAD 9, commit
    step(0, 1, 2'b10, 16'sd9, 0, 0);
    step(0, 0, 2'b00, 16'sd0, 1, 0);
    check("t3_we", {31'h0, write_enable}, 32'd1);
    check("t3_acc", {16'h0, acc_value}, 32'd9);
    check("t3_idx", {27'h0, output_index}, 32'd0);
    check("t3_op_ready", {31'h0, op_ready}, 32'd0);
    idle();
    check("t3_we_off", {31'h0, write_enable}, 32'd0);
    check("t3_idx_inc", {27'h0, output_index}, 32'd1);

    // 4: op and commit together for two cycles, then commit alone
    step(0, 1, 2'b00, 16'sd2, 1, 0);
    step(0, 1, 2'b00, 16'sd2, 1, 0);
    check("t4_no_we", {31'h0, write_enable}, 32'd0);
    step(0, 0, 2'b00, 16'sd0, 1, 0);
    check("t4_we", {31'h0, write_enable}, 32'd1);
    check("t4_acc", {16'h0, acc_value}, 32'd13);
    check("t4_idx", {27'h0, output_index}, 32'd1);
    idle();

    // 5: fill all 32 slots
    step(0, 0, 2'b00, 16'sd0, 0, 1);
    writes = 0;
    for (int i = 0; i < 80; i++) begin
      step(0, 0, 2'b00, 16'sd0, 1, 0);
      if (write_enable) writes++;
    end
    check("t5_writes", writes, 32'd32);
    check("t5_full", {31'h0, full}, 32'd1);
    check("t5_idx", {27'h0, output_index}, 32'd31);
    step(0, 0, 2'b00, 16'sd0, 0, 1);
    check("t5_clr_full", {31'h0, full}, 32'd0);
    check("t5_clr_idx", {27'h0, output_index}, 32'd0);

    // 6: reset during a write
    step(0, 1, 2'b10, 16'sh1234, 0, 0);
    step(0, 0, 2'b00, 16'sd0, 1, 0);
    check("t6_we", {31'h0, write_enable}, 32'd1);
    step(1, 0, 2'b00, 16'sd0, 0, 0);
    check("t6_we_rst", {31'h0, write_enable}, 32'd0);
    check("t6_acc_rst", {16'h0, acc_value}, 32'd0);
    check("t6_idx_rst", {27'h0, output_index}, 32'd0);

    // Randomized traffic with a few different op/commit mixes.
    for (int ph = 0; ph < 3; ph++) begin
      mode = ph;
      for (int i = 0; i < 1500; i++) begin
        bit r, ov, cv, ic;
        logic [1:0] oc;
        logic signed [15:0] opnd;
        r    = ($urandom_range(0, 299) == 0);
        ov   = (mode == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
        cv   = (mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        ic   = (mode == 1) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 19) == 0);
        oc   = 2'($urandom_range(0, 3));
        if (oc == 2'b11 && $urandom_range(0, 3) != 0) oc = 2'b00;
        opnd = (mode == 2) ? 16'($urandom_range(0, 65535)) : 16'(int'($urandom_range(0, 4000)) - 2000);
        step(r, ov, oc, opnd, cv, ic);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
